// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline registers: payload layout,
// default NOP word and the IF/ID skid buffer occupancy states.
package mips_pipe_pkg;

    localparam int unsigned PIPE_XLEN = 32;
    localparam logic [PIPE_XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [PIPE_XLEN-1:0] pc4;
        logic [PIPE_XLEN-1:0] pc8;
        logic [PIPE_XLEN-1:0] instruction;
    } if_id_payload_t;

    // Encoding doubles as the held-entry count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_state_e;

endpackage

// File: rtl/pipe_entry_reg.sv
// Payload + valid register. Clear drops only the valid bit so the
// payload stays observable; reset zeroes everything.
module pipe_entry_reg #(
    parameter int unsigned W = 96
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         valid_q;
    logic [W-1:0] data_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (i_clear) begin
            valid_q <= 1'b0;
        end else if (i_load) begin
            valid_q <= i_valid;
            data_q  <= i_data;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;

endmodule

// File: rtl/etapa_if_id_skid.sv
// IF/ID pipeline register with valid/ready handshakes, a two-entry skid
// buffer, flush, freeze and a saturating flush counter.
module etapa_if_id_skid
    import mips_pipe_pkg::*;
#(
    parameter int unsigned       NBITS     = 32,
    parameter logic [NBITS-1:0]  NOP_INSTR = NOP_INSTR_DEFAULT,
    parameter int unsigned       CNT_W     = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_enable,
    input  logic             i_flush,
    input  logic             i_if_valid,
    output logic             o_if_ready,
    input  logic [NBITS-1:0] i_pc4,
    input  logic [NBITS-1:0] i_pc8,
    input  logic [NBITS-1:0] i_instruction,
    output logic             o_id_valid,
    input  logic             i_id_ready,
    output logic [NBITS-1:0] o_pc4,
    output logic [NBITS-1:0] o_pc8,
    output logic [NBITS-1:0] o_instruction,
    output logic [1:0]       o_occupancy,
    output logic [CNT_W-1:0] o_flush_count
);

    localparam int unsigned W = 3 * NBITS;

    occ_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W+1:0] cnt_sum;
    logic [1:0]       discard;

    logic         main_valid, skid_valid;
    logic [W-1:0] main_data, skid_data, in_data, main_in;
    logic         main_load, main_clear, main_from_skid;
    logic         skid_load, skid_clear;
    logic         in_xfer, out_xfer;

    assign in_data    = {i_pc4, i_pc8, i_instruction};
    assign main_in    = main_from_skid ? skid_data : in_data;

    // Ready looks only at skid state, never at i_id_ready.
    assign o_if_ready = i_reset_n & i_enable & ~skid_valid;
    assign o_id_valid = main_valid & i_enable;
    assign in_xfer    = i_if_valid & o_if_ready;
    assign out_xfer   = o_id_valid & i_id_ready;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        discard        = 2'(state_q) - {1'b0, out_xfer};
        cnt_sum        = {2'b00, cnt_q} + {{CNT_W{1'b0}}, discard};
        if (i_enable) begin
            if (i_flush) begin
                state_d    = EMPTY;
                main_clear = 1'b1;
                skid_clear = 1'b1;
                cnt_d      = (cnt_sum > {2'b00, {CNT_W{1'b1}}}) ? '1 : cnt_sum[CNT_W-1:0];
            end else begin
                unique case (state_q)
                    EMPTY: if (in_xfer) begin
                        main_load = 1'b1;
                        state_d   = ONE;
                    end
                    ONE: begin
                        if (in_xfer && out_xfer) begin
                            main_load = 1'b1;
                        end else if (in_xfer) begin
                            skid_load = 1'b1;
                            state_d   = FULL;
                        end else if (out_xfer) begin
                            main_clear = 1'b1;
                            state_d    = EMPTY;
                        end
                    end
                    FULL: if (out_xfer) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                        state_d        = ONE;
                    end
                    default: state_d = EMPTY;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    pipe_entry_reg #(.W(W)) u_main (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_load    (main_load),
        .i_clear   (main_clear),
        .i_valid   (1'b1),
        .i_data    (main_in),
        .o_valid   (main_valid),
        .o_data    (main_data)
    );

    pipe_entry_reg #(.W(W)) u_skid (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_load    (skid_load),
        .i_clear   (skid_clear),
        .i_valid   (1'b1),
        .i_data    (in_data),
        .o_valid   (skid_valid),
        .o_data    (skid_data)
    );

    assign o_pc4         = main_data[W-1 -: NBITS];
    assign o_pc8         = main_data[2*NBITS-1 -: NBITS];
    assign o_instruction = o_id_valid ? main_data[NBITS-1:0] : NOP_INSTR;
    assign o_occupancy   = state_q;
    assign o_flush_count = cnt_q;

endmodule

// File: tb/tb_etapa_if_id_skid.sv
// Directed bench for etapa_if_id_skid; a second instance with CNT_W=2
// shares the stimulus to exercise counter saturation.
module tb_etapa_if_id_skid;

    logic        clk = 1'b0;
    logic        reset_n, enable, flush, if_valid, id_ready;
    logic [31:0] pc4, pc8, instr;

    logic        if_ready, id_valid;
    logic [31:0] o_pc4, o_pc8, o_instr;
    logic [1:0]  occ;
    logic [7:0]  fcnt;

    logic        if_ready2, id_valid2;
    logic [31:0] o_pc4_2, o_pc8_2, o_instr_2;
    logic [1:0]  occ2;
    logic [1:0]  fcnt2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    etapa_if_id_skid #(.NBITS(32), .NOP_INSTR(32'h0000_0000), .CNT_W(8)) dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_enable(enable), .i_flush(flush),
        .i_if_valid(if_valid), .o_if_ready(if_ready),
        .i_pc4(pc4), .i_pc8(pc8), .i_instruction(instr),
        .o_id_valid(id_valid), .i_id_ready(id_ready),
        .o_pc4(o_pc4), .o_pc8(o_pc8), .o_instruction(o_instr),
        .o_occupancy(occ), .o_flush_count(fcnt)
    );

    etapa_if_id_skid #(.NBITS(32), .NOP_INSTR(32'h0000_0000), .CNT_W(2)) dut_sat (
        .i_clk(clk), .i_reset_n(reset_n), .i_enable(enable), .i_flush(flush),
        .i_if_valid(if_valid), .o_if_ready(if_ready2),
        .i_pc4(pc4), .i_pc8(pc8), .i_instruction(instr),
        .o_id_valid(id_valid2), .i_id_ready(id_ready),
        .o_pc4(o_pc4_2), .o_pc8(o_pc8_2), .o_instruction(o_instr_2),
        .o_occupancy(occ2), .o_flush_count(fcnt2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] p);
        pc4   = p;
        pc8   = p + 32'd4;
        instr = 32'hA000_0000 | p;
    endtask

    // Two accepted payloads with ID stalled, then a flush with a fresh offer.
    task automatic fill_and_flush(input logic [31:0] base, input logic rdy_at_flush);
        flush = 1'b0; if_valid = 1'b1; id_ready = 1'b0;
        offer(base);          tick();
        offer(base + 32'h4);  tick();
        check("fill_occ", 64'(occ), 64'd2);
        flush = 1'b1; id_ready = rdy_at_flush; offer(32'h2108_000A);
        tick();
        check("flush_occ", 64'(occ), 64'd0);
        check("flush_nop", 64'(o_instr), 64'h0);
        flush = 1'b0; if_valid = 1'b0; id_ready = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b1; flush = 1'b0; if_valid = 1'b1; id_ready = 1'b1;
        offer(32'h100);
        repeat (3) tick();
        check("rst_if_ready", 64'(if_ready), 64'd0);
        check("rst_id_valid", 64'(id_valid), 64'd0);
        check("rst_instr", 64'(o_instr), 64'h0);
        check("rst_pc4", 64'(o_pc4), 64'h0);
        check("rst_occ", 64'(occ), 64'd0);
        check("rst_cnt", 64'(fcnt), 64'd0);

        reset_n = 1'b1; if_valid = 1'b0;
        #1;
        check("rel_if_ready", 64'(if_ready), 64'd1);

        // Streaming
        if_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            offer(32'(4 * k));
            tick();
            check("strm_valid", 64'(id_valid), 64'd1);
            check("strm_pc4", 64'(o_pc4), 64'(4 * k));
            check("strm_pc8", 64'(o_pc8), 64'(4 * k + 4));
            check("strm_occ", 64'(occ), 64'd1);
        end
        if_valid = 1'b0;
        tick();
        check("drain_occ", 64'(occ), 64'd0);
        check("drain_nop", 64'(o_instr), 64'h0);
        check("drain_pc4_kept", 64'(o_pc4), 64'h10);

        // Stall / skid
        if_valid = 1'b1;
        offer(32'h4); tick();
        offer(32'h8); tick();
        check("stl_pc4_a", 64'(o_pc4), 64'h8);
        id_ready = 1'b0; offer(32'hC); tick();
        check("stl_occ2", 64'(occ), 64'd2);
        check("stl_if_ready", 64'(if_ready), 64'd0);
        check("stl_hold", 64'(o_pc4), 64'h8);
        offer(32'h10);
        repeat (2) begin
            tick();
            check("stl_hold2", 64'(o_pc4), 64'h8);
            check("stl_occ_hold", 64'(occ), 64'd2);
        end
        id_ready = 1'b1; tick();
        check("rel_pc4_c", 64'(o_pc4), 64'hC);
        check("rel_occ", 64'(occ), 64'd1);
        check("rel_ready_back", 64'(if_ready), 64'd1);
        tick();
        check("rel_pc4_10", 64'(o_pc4), 64'h10);
        check("rel_instr_10", 64'(o_instr), 64'hA000_0010);
        if_valid = 1'b0; tick();
        check("rel_empty", 64'(occ), 64'd0);

        // Flush when FULL
        fill_and_flush(32'h20, 1'b0);
        check("fl1_cnt", 64'(fcnt), 64'd2);
        check("fl1_cnt_sat", 64'(fcnt2), 64'd2);
        tick();
        check("fl1_dropped", 64'(id_valid), 64'd0);

        // Freeze
        if_valid = 1'b1; id_ready = 1'b0; offer(32'h30); tick();
        enable = 1'b0; flush = 1'b1; offer(32'h34);
        #1;
        check("frz_if_ready", 64'(if_ready), 64'd0);
        check("frz_id_valid", 64'(id_valid), 64'd0);
        repeat (5) tick();
        check("frz_occ", 64'(occ), 64'd1);
        check("frz_cnt", 64'(fcnt), 64'd2);
        enable = 1'b1; flush = 1'b0; if_valid = 1'b0;
        #1;
        check("unfrz_valid", 64'(id_valid), 64'd1);
        check("unfrz_pc4", 64'(o_pc4), 64'h30);
        check("unfrz_instr", 64'(o_instr), 64'hA000_0030);
        id_ready = 1'b1; tick();
        check("unfrz_drain", 64'(occ), 64'd0);

        // Saturation: CNT_W=2 instance tops out at 3
        fill_and_flush(32'h40, 1'b0);
        check("fl2_cnt", 64'(fcnt), 64'd4);
        check("fl2_cnt_sat", 64'(fcnt2), 64'd3);
        fill_and_flush(32'h50, 1'b0);
        check("fl3_cnt", 64'(fcnt), 64'd6);
        check("fl3_cnt_sat", 64'(fcnt2), 64'd3);
        // Flush with a simultaneous ID consume discards only one entry
        fill_and_flush(32'h60, 1'b1);
        check("fl4_cnt", 64'(fcnt), 64'd7);

        // Reset wins over flush and transfers
        if_valid = 1'b1; offer(32'h70); tick();
        reset_n = 1'b0; flush = 1'b1; tick();
        check("rst2_occ", 64'(occ), 64'd0);
        check("rst2_cnt", 64'(fcnt), 64'd0);
        check("rst2_pc4", 64'(o_pc4), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
